// File: rtl/mem_stage_lsu_pkg.sv
// mem_pkg: memory op encoding, op-class helpers and byte-lane select constants shared by the MEM stage.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_t;

    localparam logic [3:0] SEL_NONE    = 4'b0000;
    localparam logic [3:0] SEL_BYTE0   = 4'b0001;
    localparam logic [3:0] SEL_LO_HALF = 4'b0011;
    localparam logic [3:0] SEL_HI_HALF = 4'b1100;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    function automatic logic is_load(input mem_op_t op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input mem_op_t op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input mem_op_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-RAM port bundle: the LSU is master (drives enable/sel/addr/wdata), the RAM is slave (returns rdata combinationally).
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dm_en;
    logic              dm_we;
    logic [3:0]        dm_sel;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;

    modport master (
        output dm_en, dm_we, dm_sel, dm_addr, dm_wdata,
        input  dm_rdata
    );

    modport slave (
        input  dm_en, dm_we, dm_sel, dm_addr, dm_wdata,
        output dm_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational store lane replication / byte-select and load lane extract + sign/zero extend.
// Zero latency; no state, so no backpressure of its own.
module lsu_align
    import mem_pkg::*;
(
    input  mem_op_t     i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_sel   = SEL_NONE;
        o_wdata = 32'd0;
        case (i_op)
            OP_SB: begin
                o_sel   = SEL_BYTE0 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            OP_SH: begin
                o_sel   = i_addr_lo[1] ? SEL_HI_HALF : SEL_LO_HALF;
                o_wdata = {2{i_wdata[15:0]}};
            end
            OP_SW: begin
                o_sel   = SEL_WORD;
                o_wdata = i_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        // Halfword lane follows addr[1] only; addr[0] is ignored when misaligned.
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load_data = 32'd0;
        case (i_op)
            OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load_data = {24'd0, w_byte};
            OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load_data = {16'd0, w_half};
            OP_LW:   o_load_data = i_rdata;
            default: o_load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: EX/MEM and MEM/WB registers around the data RAM; load result reaches WB one cycle after MEM.
// stall_i freezes both registers and blocks RAM writes; flush_i bubbles EX/MEM. MEM_ADDR_EXC_EN enables misalignment faults.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ex_valid,
    input  mem_op_t           ex_mem_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic [4:0]        ex_wreg,
    input  logic              ex_wreg_en,
    mem_stage_lsu_if.master   dm,
    output logic [4:0]        mem_wreg,
    output logic              mem_wreg_en,
    output logic              mem_is_load,
    output logic              wb_valid,
    output logic [4:0]        wb_wreg,
    output logic              wb_wreg_en,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_exc
);

    logic              r_m_valid;
    mem_op_t           r_m_op;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_m_alu_res;
    logic [4:0]        r_m_wreg;
    logic              r_m_wreg_en;

    logic              r_wb_valid;
    logic [4:0]        r_wb_wreg;
    logic              r_wb_wreg_en;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_exc;
    logic              w_is_load;
    logic              w_is_store;
    logic [3:0]        w_sel;
    logic [31:0]       w_wdata_lane;
    logic [31:0]       w_load_data;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_m_valid   <= 1'b0;
            r_m_op      <= OP_NONE;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_m_alu_res <= '0;
            r_m_wreg    <= 5'd0;
            r_m_wreg_en <= 1'b0;
        end else if (flush_i) begin
            r_m_valid   <= 1'b0;
        end else if (!stall_i) begin
            r_m_valid   <= ex_valid;
            r_m_op      <= ex_mem_op;
            r_m_addr    <= ex_addr;
            r_m_wdata   <= ex_wdata;
            r_m_alu_res <= ex_alu_res;
            r_m_wreg    <= ex_wreg;
            r_m_wreg_en <= ex_wreg_en;
        end
    end

    assign w_is_load  = is_load(r_m_op);
    assign w_is_store = is_store(r_m_op);

`ifdef MEM_ADDR_EXC_EN
    assign w_exc = r_m_valid &
                   ((is_half(r_m_op) & r_m_addr[0]) |
                    (is_word(r_m_op) & (|r_m_addr[1:0])));
`else
    assign w_exc = 1'b0;
`endif

    lsu_align u_align (
        .i_op        (r_m_op),
        .i_addr_lo   (r_m_addr[1:0]),
        .i_wdata     (r_m_wdata[31:0]),
        .i_rdata     (dm.dm_rdata[31:0]),
        .o_sel       (w_sel),
        .o_wdata     (w_wdata_lane),
        .o_load_data (w_load_data)
    );

    // rstn gates enable/write directly so a store in flight cannot land on the reset edge.
    assign dm.dm_en    = rstn & r_m_valid & (w_is_load | w_is_store) & ~w_exc;
    assign dm.dm_we    = rstn & r_m_valid & w_is_store & ~stall_i & ~w_exc;
    assign dm.dm_sel   = w_sel;
    assign dm.dm_addr  = r_m_addr;
    assign dm.dm_wdata = w_wdata_lane;

    assign mem_wreg    = r_m_wreg;
    assign mem_wreg_en = r_m_wreg_en & r_m_valid;
    assign mem_is_load = r_m_valid & w_is_load;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wb_valid   <= 1'b0;
            r_wb_wreg    <= 5'd0;
            r_wb_wreg_en <= 1'b0;
            r_wb_data    <= '0;
        end else if (!stall_i) begin
            r_wb_valid   <= r_m_valid;
            r_wb_wreg    <= r_m_wreg;
            r_wb_wreg_en <= r_m_wreg_en & r_m_valid & ~w_exc;
            r_wb_data    <= w_is_load ? w_load_data : r_m_alu_res;
        end
    end

`ifdef MEM_ADDR_EXC_EN
    logic r_wb_exc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wb_exc <= 1'b0;
        end else if (!stall_i) begin
            r_wb_exc <= w_exc;
        end
    end

    assign wb_exc = r_wb_exc;
`else
    assign wb_exc = 1'b0;
`endif

    assign wb_valid   = r_wb_valid;
    assign wb_wreg    = r_wb_wreg;
    assign wb_wreg_en = r_wb_wreg_en;
    assign wb_data    = r_wb_data;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: inputs change 1 time unit after posedge, outputs checked before the next edge.
module tb_mem_stage_lsu;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall_i;
    logic        flush_i;
    logic        ex_valid;
    mem_op_t     ex_mem_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [31:0] ex_alu_res;
    logic [4:0]  ex_wreg;
    logic        ex_wreg_en;
    logic [4:0]  mem_wreg;
    logic        mem_wreg_en;
    logic        mem_is_load;
    logic        wb_valid;
    logic [4:0]  wb_wreg;
    logic        wb_wreg_en;
    logic [31:0] wb_data;
    logic        wb_exc;
    logic [31:0] ram_rdata;

    int n_vec  = 0;
    int n_miss = 0;
    int n_wr   = 0;
    int wr_snap;

    mem_stage_lsu_if dm_bus ();
    assign dm_bus.dm_rdata = ram_rdata;

    mem_stage_lsu dut (
        .clk         (clk),
        .rstn        (rstn),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .ex_valid    (ex_valid),
        .ex_mem_op   (ex_mem_op),
        .ex_addr     (ex_addr),
        .ex_wdata    (ex_wdata),
        .ex_alu_res  (ex_alu_res),
        .ex_wreg     (ex_wreg),
        .ex_wreg_en  (ex_wreg_en),
        .dm          (dm_bus.master),
        .mem_wreg    (mem_wreg),
        .mem_wreg_en (mem_wreg_en),
        .mem_is_load (mem_is_load),
        .wb_valid    (wb_valid),
        .wb_wreg     (wb_wreg),
        .wb_wreg_en  (wb_wreg_en),
        .wb_data     (wb_data),
        .wb_exc      (wb_exc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_bus.dm_we === 1'b1) n_wr <= n_wr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input mem_op_t op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] alu,
                         input logic [4:0] wr, input logic we);
        ex_valid   = v;
        ex_mem_op  = op;
        ex_addr    = a;
        ex_wdata   = wd;
        ex_alu_res = alu;
        ex_wreg    = wr;
        ex_wreg_en = we;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn      = 1'b0;
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        ram_rdata = 32'h80F1_7F01;
        drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        tick();
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data",  wb_data,       32'd0);
        check("rst_dm_en",    32'(dm_bus.dm_en), 32'd0);
        check("rst_is_load",  32'(mem_is_load),  32'd0);

        // Store in flight killed by reset
        rstn = 1'b1;
        drive(1'b1, OP_SW, 32'h40, 32'h1122_3344, 32'h0, 5'd2, 1'b0);
        tick();
        check("pre_rst_we", 32'(dm_bus.dm_we), 32'd1);
        rstn = 1'b0;
        drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        check("rstlow_we", 32'(dm_bus.dm_we), 32'd0);
        check("rstlow_en", 32'(dm_bus.dm_en), 32'd0);
        wr_snap = n_wr;
        tick();
        check("rst_no_write", 32'(n_wr),           32'(wr_snap));
        check("rst_sel",      32'(dm_bus.dm_sel),  32'd0);
        check("rst_addr",     dm_bus.dm_addr,      32'd0);
        check("rst_wreg",     32'(mem_wreg),       32'd0);
        check("rst_wb_v2",    32'(wb_valid),       32'd0);
        rstn = 1'b1;

        // Stores
        wr_snap = n_wr;
        drive(1'b1, OP_SB, 32'h41, 32'h1122_3344, 32'h0, 5'd0, 1'b0);
        tick();
        check("sb_sel",   32'(dm_bus.dm_sel), 32'b0010);
        check("sb_wdata", dm_bus.dm_wdata,    32'h4444_4444);
        check("sb_we",    32'(dm_bus.dm_we),  32'd1);
        check("sb_addr",  dm_bus.dm_addr,     32'h41);
        drive(1'b1, OP_SH, 32'h42, 32'h1122_3344, 32'h0, 5'd0, 1'b0);
        tick();
        check("sh_sel",   32'(dm_bus.dm_sel), 32'b1100);
        check("sh_wdata", dm_bus.dm_wdata,    32'h3344_3344);
        drive(1'b1, OP_SW, 32'h40, 32'h1122_3344, 32'h0, 5'd0, 1'b0);
        tick();
        check("sw_sel",   32'(dm_bus.dm_sel), 32'b1111);
        check("sw_wdata", dm_bus.dm_wdata,    32'h1122_3344);
        drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        check("store_writes", 32'(n_wr), 32'(wr_snap + 3));

        // Loads against rdata 0x80F17F01
        drive(1'b1, OP_LB, 32'h43, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        check("lb_is_load",  32'(mem_is_load), 32'd1);
        check("lb_mwreg",    32'(mem_wreg),    32'd5);
        check("lb_mwreg_en", 32'(mem_wreg_en), 32'd1);
        check("lb_dm_en",    32'(dm_bus.dm_en), 32'd1);
        check("lb_sel",      32'(dm_bus.dm_sel), 32'd0);
        drive(1'b1, OP_LBU, 32'h43, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        check("lb_data",     wb_data,          32'hFFFF_FF80);
        check("lb_wb_valid", 32'(wb_valid),    32'd1);
        check("lb_wb_en",    32'(wb_wreg_en),  32'd1);
        drive(1'b1, OP_LH, 32'h40, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        check("lbu_data", wb_data, 32'h0000_0080);
        drive(1'b1, OP_LHU, 32'h42, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        check("lh_data", wb_data, 32'h0000_7F01);
        drive(1'b1, OP_LW, 32'h40, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        check("lhu_data", wb_data, 32'h0000_80F1);
        drive(1'b1, OP_NONE, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b1);
        tick();
        check("lw_data",   wb_data,           32'h80F1_7F01);
        check("none_dmen", 32'(dm_bus.dm_en), 32'd0);
        drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        check("none_data", wb_data,      32'hDEAD_BEEF);
        check("none_wreg", 32'(wb_wreg), 32'd7);

        // Stall on a store: no write while stalled, exactly one on release
        drive(1'b1, OP_NONE, 32'h0, 32'h0, 32'h1234_5678, 5'd3, 1'b1);
        tick();
        drive(1'b1, OP_SW, 32'h44, 32'hCAFE_F00D, 32'h0BAD_0001, 5'd0, 1'b0);
        tick();
        stall_i = 1'b1;
        drive(1'b1, OP_LW, 32'h80, 32'h0, 32'h0, 5'd1, 1'b1);
        wr_snap = n_wr;
        #1;
        check("stall_we0", 32'(dm_bus.dm_we), 32'd0);
        check("stall_en",  32'(dm_bus.dm_en), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_we",   32'(dm_bus.dm_we), 32'd0);
            check("stall_wbd",  wb_data,           32'h1234_5678);
            check("stall_addr", dm_bus.dm_addr,    32'h44);
        end
        check("stall_nowr", 32'(n_wr), 32'(wr_snap));
        stall_i = 1'b0;
        drive(1'b1, OP_NONE, 32'h0, 32'h0, 32'h5A5A_5A5A, 5'd6, 1'b1);
        #1;
        check("release_we", 32'(dm_bus.dm_we), 32'd1);
        tick();
        check("one_write",  32'(n_wr),         32'(wr_snap + 1));
        check("sw_wb_data", wb_data,           32'h0BAD_0001);
        check("sw_wb_en",   32'(wb_wreg_en),   32'd0);
        check("post_we",    32'(dm_bus.dm_we), 32'd0);

        // Flush and stall together on a load
        drive(1'b1, OP_LW, 32'h40, 32'h0, 32'h0, 5'd9, 1'b1);
        tick();
        check("fl_pre_load", 32'(mem_is_load), 32'd1);
        check("fl_pre_wbd",  wb_data,          32'h5A5A_5A5A);
        stall_i = 1'b1;
        flush_i = 1'b1;
        drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        check("fl_is_load", 32'(mem_is_load),  32'd0);
        check("fl_dm_en",   32'(dm_bus.dm_en), 32'd0);
        check("fl_mwe",     32'(mem_wreg_en),  32'd0);
        check("fl_wbd",     wb_data,           32'h5A5A_5A5A);
        check("fl_wbwreg",  32'(wb_wreg),      32'd6);
        stall_i = 1'b0;
        flush_i = 1'b0;
        tick();
        check("fl_bubble_v",  32'(wb_valid),   32'd0);
        check("fl_bubble_we", 32'(wb_wreg_en), 32'd0);

        // Misaligned word load
        drive(1'b1, OP_LW, 32'h42, 32'h0, 32'h0, 5'd4, 1'b1);
        tick();
        drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
`ifdef MEM_ADDR_EXC_EN
        check("exc_dm_en", 32'(dm_bus.dm_en), 32'd0);
        tick();
        check("exc_flag",  32'(wb_exc),     32'd1);
        check("exc_wb_en", 32'(wb_wreg_en), 32'd0);
`else
        check("mis_dm_en", 32'(dm_bus.dm_en), 32'd1);
        tick();
        check("mis_data",  wb_data,         32'h80F1_7F01);
        check("mis_exc",   32'(wb_exc),     32'd0);
        check("mis_wb_en", 32'(wb_wreg_en), 32'd1);
`endif
        check("mis_wreg", 32'(wb_wreg), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM pipeline stage that sits between the EX stage and the data RAM, and feeds write-back.
- Registers EX results (EX/MEM register) and drives the data RAM's enable, write-enable, byte-select, address and write data.
- Aligns and extends read data for byte, halfword and word loads.
- Registers the result into the MEM/WB register, with stall and flush control and hazard-visible status.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 (byte lanes are hard-wired).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- stall_i  in  1  freeze both stage registers
- flush_i  in  1  load a bubble into EX/MEM
- ex_valid  in  1  EX result valid
- ex_mem_op  in  4  memory op code (package enum)
- ex_addr  in  32  effective address
- ex_wdata  in  32  store data (rt)
- ex_alu_res  in  32  non-memory result
- ex_wreg  in  5  destination register
- ex_wreg_en  in  1  destination write enable
- dm_en  out  1  data RAM enable
- dm_we  out  1  data RAM write enable
- dm_sel  out  4  byte-lane select
- dm_addr  out  32  data RAM address
- dm_wdata  out  32  lane-aligned store data
- dm_rdata  in  32  data RAM read data (combinational)
- mem_wreg  out  5  EX/MEM destination, for forwarding/hazard
- mem_wreg_en  out  1  EX/MEM wreg_en AND m_valid
- mem_is_load  out  1  EX/MEM holds a valid load
- wb_valid  out  1  MEM/WB valid
- wb_wreg  out  5  MEM/WB destination register
- wb_wreg_en  out  1  MEM/WB write enable
- wb_data  out  32  MEM/WB write-back data
- wb_exc  out  1  address-error flag (see Optional Feature)

Behaviour:
- Reset: rstn sampled at posedge clk only.
  - Both registers cleared: all outputs 0, m_valid=0, wb_valid=0.
  - dm_en/dm_we are forced to 0 combinationally while rstn=0.
  - Reset mid-access kills any in-flight store before its write edge.
- EX/MEM register update, by priority:
  - flush_i=1: m_valid←0, other fields don't-care. Flush has priority over stall.
  - else stall_i=1: hold.
  - else: capture all ex_* fields.
- MEM/WB register update:
  - stall_i=1: hold.
  - else: wb_valid←m_valid, wb_wreg←m_wreg, wb_wreg_en←m_wreg_en&m_valid, wb_data←load_result for loads, else m_alu_res.
  - Load-to-WB latency is 1 cycle: RAM read is combinational within MEM.
- Data RAM drive (combinational from EX/MEM register):
  - dm_addr = m_addr.
  - dm_en = m_valid & (load|store).
  - dm_we = m_valid & store & ~stall_i & ~exc. A stalled store does not write until the stage advances; a store writes exactly once.
- Stores:
  - SB: dm_sel=1<<addr[1:0], dm_wdata={4{wdata[7:0]}}.
  - SH: dm_sel=addr[1]?4'b1100:4'b0011, dm_wdata={2{wdata[15:0]}}.
  - SW: dm_sel=4'b1111, dm_wdata=wdata.
  - Loads and NONE: dm_sel=0, dm_wdata=0.
- Loads: lane picked by addr[1:0], then extended.
  - LB/LBU: sign/zero-extend rdata byte lane.
  - LH/LHU: lane addr[1]; sign/zero-extend.
  - LW: rdata unchanged.
- Simultaneous stall_i and flush_i: EX/MEM bubbles, MEM/WB holds.
- NONE op with valid=1: pass-through of alu_res, no RAM access.

Optional Feature:
- Macro MEM_ADDR_EXC_EN.
- Defined:
  - exc = m_valid & ((half op & addr[0]) | (word op & |addr[1:0])).
  - On exc: dm_we=0 and dm_en=0; wb_exc←exc; wb_wreg_en←0.
- Undefined:
  - exc tied 0 and wb_exc tied 0.
  - Misaligned halfword/word accesses use addr with low bits ignored: halfword lane by addr[1], word lane 0.

Decomposition:
- Package mem_pkg holds:
  - mem_op enum: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8.
  - is_load / is_store helper constants.
  - Lane-select constants.
- One sub-module, lsu_align: purely combinational store-lane/sel generation and load extract/extend. Registers stay in the top.

Test Plan:
- Reset: rstn=0 with valid SW in flight → no RAM write; all outputs 0 the next cycle.
- Stores to 0x41, wdata=0x11223344:
  - SB → dm_sel=0010, dm_wdata=0x44444444.
  - SH to 0x42 → dm_sel=1100, dm_wdata=0x33443344.
  - SW to 0x40 → 1111, 0x11223344.
- Loads with rdata=0x80F17F01:
  - LB @0x43 → wb_data=0xFFFFFF80.
  - LBU @0x43 → 0x00000080.
  - LH @0x40 → 0x00007F01.
  - LHU @0x42 → 0x000080F1.
  - LW → 0x80F17F01, all 1 cycle after MEM.
- Stall 3 cycles on SW → dm_we=0 while stalled, exactly one write on release; MEM/WB held.
- flush_i and stall_i together on a load → EX/MEM bubble (mem_is_load=0), wb unchanged.
- With MEM_ADDR_EXC_EN, LW @0x42 → wb_exc=1, wb_wreg_en=0, dm_en=0. Without it → word @0x40 returned, wb_exc=0.
